axi_buffer_arb_rab: RTL

Round-robin arbiter that shares one downstream buffered channel (e.g. the W or B path into an `axi_buffer_rab` instance) among `N_PORTS` upstream requesters. Grants are locked from first valid until the beat carrying `last` completes, so bursts are never interleaved and a presented beat is never withdrawn. It sits in front of the shared buffer inside the RAB slave-port datapath. It adds no storage and no latency; the only state is the lock FSM and the round-robin pointer.

---
 rtl/axi_buffer_arb_rab.sv | 111 +++++++++++
 1 files changed

// File: rtl/axi_buffer_arb_rab.sv
// Round-robin burst-locking arbiter feeding one shared RAB buffer channel.
// Pure combinational datapath; the only state is the lock FSM and the rr pointer.
module axi_buffer_arb_rab #(
  parameter  int DATA_WIDTH = 64,
  parameter  int N_PORTS    = 4,
  localparam int ID_WIDTH   = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_PORTS-1:0]            in_valid,
  input  logic [N_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [N_PORTS-1:0]            in_last,
  output logic [N_PORTS-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t              state, state_nx;
  logic [ID_WIDTH-1:0] rr_ptr, rr_nx;
  logic [ID_WIDTH-1:0] lock_id, lock_nx;

  logic                scan_found;
  logic [ID_WIDTH-1:0] scan_id;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_valid;
  logic                hs;

  // Explicit compare keeps the pointer in range for non-power-of-2 port counts.
  function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(N_PORTS - 1)) ? '0 : p + ID_WIDTH'(1);
  endfunction

  always_comb begin
    int idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_id    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!scan_found && in_valid[ID_WIDTH'(idx)]) begin
        scan_found = 1'b1;
        scan_id    = ID_WIDTH'(idx);
      end
    end
  end

  // While locked, the grant ignores every other requester, even across valid gaps.
  always_comb begin
    win_id    = scan_id;
    win_valid = scan_found;
    if (state == LOCKED) begin
      win_id    = lock_id;
      win_valid = in_valid[lock_id];
    end
  end

  always_comb begin
    out_valid        = win_valid;
    out_data         = in_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
    out_last         = in_last[win_id];
    out_id           = win_id;
    in_ready         = '0;
    in_ready[win_id] = out_ready & win_valid;
    hs               = win_valid & out_ready;
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    lock_nx  = lock_id;
    case (state)
      IDLE: begin
        if (hs && out_last) begin
          rr_nx = ptr_inc(win_id);
        end else if (out_valid) begin
          state_nx = LOCKED;
          lock_nx  = win_id;
        end
      end
      LOCKED: begin
        if (hs && out_last) begin
          state_nx = IDLE;
          rr_nx    = ptr_inc(lock_id);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_nx;
      lock_id <= lock_nx;
    end
  end

endmodule
